counter_ud_trig: RTL and testbench
==================================

// Module: counter_ud_trig
// PURPOSE
//  Parametrised up/down modulo counter with per-bit trigger outputs; successor of the plain
//  binary up-counter. Adds programmable modulus, direction, synchronous load and a terminal-
//  count pulse. trig_out bits drive cascaded timers/prescalers: bit i pulses when bit i
//  "carries" (up) or "borrows" (down).
// PARAMETERS
//  WIDTH    8         counter width in bits (>=2)
//  MODULUS  2**WIDTH  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk       in   1      clock, all state on rising edge
//  n_rst     in   1      reset, asynchronous, active-low
//  n_en      in   1      count enable, active-low (0 = count, 1 = hold)
//  up        in   1      direction: 1 = increment, 0 = decrement
//  n_ld      in   1      synchronous load strobe, active-low
//  ld_val    in   WIDTH  value to load
//  count     out  WIDTH  current count, registered
//  trig_out  out  WIDTH  per-bit carry/borrow pulses, registered
//  tc        out  1      terminal-count (wrap) pulse, registered
// BEHAVIOUR
//  - Reset (n_rst=0, any time, async): count=0, trig_out=0, tc=0. Released synchronously
//    by the source; first count step on first rising edge with n_rst=1 and n_en=0.
//  - Priority per edge: load > count > hold.
//  - Load (n_ld=0, regardless of n_en/up): count <= min(ld_val, MODULUS-1);
//    trig_out <= 0; tc <= 0.
//  - Count up (n_ld=1, n_en=0, up=1): next = (count==MODULUS-1) ? 0 : count+1.
//  - Count down (n_ld=1, n_en=0, up=0): next = (count==0) ? MODULUS-1 : count-1.
//  - Hold (n_ld=1, n_en=1): count, and trig_out <= 0, tc <= 0.
//  - trig_out registered on same edge as count update, so valid in first cycle of new count:
//      up:   trig_out <= count & ~next      (bits falling 1->0)
//      down: trig_out <= ~count & next      (bits rising 0->1)
//    Each bit is a single-cycle pulse unless the next edge repeats the transition.
//  - tc <= 1 for one cycle on the edge where count wraps (up: MODULUS-1 -> 0;
//    down: 0 -> MODULUS-1), else 0.
//  - Full-range wrap (MODULUS=2**WIDTH), up from all-ones: count=0, trig_out='1, tc=1.
//  - Non-power-of-2 wrap, e.g. WIDTH=4, MODULUS=10, up 9->0: trig_out=4'b1001, tc=1.
//  - Direction change mid-run is legal on any edge; next value uses new up value.
//  - n_rst asserted mid-count overrides load/enable immediately.
//  - All arithmetic in WIDTH bits; no intermediate wider than WIDTH+1.
// STRUCTURE
//  - counter_pkg: typedef enum logic {DIR_DOWN=0, DIR_UP=1} dir_e; function
//    next_count(count, dir, modulus) returning WIDTH-bit next value, shared with
//    other counters.
//  - Sub-module counter_trig_gen (combinational): inputs count, next, dir; outputs
//    trig vector and wrap flag. Top holds the three registers and load/enable priority.
//  - No other hierarchy; no generate-per-bit logic needed.
// TESTING (WIDTH=4 unless noted; 10 ns clock; n_rst released after 5 cycles)
//  - Up full range, MODULUS=16, n_en=0, up=1: count 0..15 then 0; each step
//    trig_out == prev & ~count; at 15->0 trig_out=4'hF, tc=1; tc=0 elsewhere.
//  - Down, MODULUS=16: from 0 -> 15 with trig_out=4'hF, tc=1; 15->14 trig_out=0;
//    8->7 trig_out=4'b0111.
//  - Modulus 10 up: 9->0 gives trig_out=4'b1001, tc=1; down 0->9 gives trig_out=4'b1001, tc=1.
//  - Hold/load: n_en=1 for 2 cycles -> count frozen, trig_out=0, tc=0; n_ld=0, ld_val=5 with
//    n_en=0 -> count=5, trig_out=0; MODULUS=10, ld_val=12 -> count=9.
//  - Async reset mid-count: drop n_rst between edges at count=7 -> count, trig_out, tc read 0
//    before next edge; after release count restarts 0,1,2.

Source files
------------

// File: rtl/counter_ud_trig_pkg.sv
// Shared counter types and the modulo next-value helper used by counter blocks.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Widest counter the helper supports.
    localparam int unsigned CNT_MAX_W = 32;

    // Modulo step. Callers zero-extend to CNT_MAX_W and truncate the result.
    // The count only moves by one and never leaves 0..modulus-1, so the
    // truncated result equals the WIDTH-bit result.
    function automatic logic [CNT_MAX_W-1:0] next_count(
        input logic [CNT_MAX_W-1:0] count,
        input dir_e                 dir,
        input logic [CNT_MAX_W:0]   modulus
    );
        logic [CNT_MAX_W-1:0] top;
        logic [CNT_MAX_W-1:0] nxt;
        top = CNT_MAX_W'(modulus - (CNT_MAX_W+1)'(1));
        if (dir == DIR_UP) begin
            nxt = (count == top) ? '0 : count + CNT_MAX_W'(1);
        end else begin
            nxt = (count == '0) ? top : count - CNT_MAX_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/counter_ud_trig_if.sv
// Control/status bundle of the up/down trigger counter.
interface counter_ud_trig_if #(
    parameter int WIDTH = 8
);
    logic             n_en;
    logic             up;
    logic             n_ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] trig_out;
    logic             tc;

    modport master (
        output n_en, up, n_ld, ld_val,
        input  count, trig_out, tc
    );

    modport slave (
        input  n_en, up, n_ld, ld_val,
        output count, trig_out, tc
    );
endinterface

// File: rtl/counter_ud_trig_trig_gen.sv
// Combinational carry/borrow pulse and wrap detection for one count step.
module counter_trig_gen
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] next,
    input  dir_e             dir,
    output logic [WIDTH-1:0] trig,
    output logic             wrap
);

    // Up: bits falling 1->0 carried; down: bits rising 0->1 borrowed.
    // A single step only goes backwards in value when it wraps.
    always_comb begin
        trig = '0;
        wrap = 1'b0;
        if (dir == DIR_UP) begin
            trig = count & ~next;
            wrap = (next < count);
        end else begin
            trig = ~count & next;
            wrap = (next > count);
        end
    end

endmodule

// File: rtl/counter_ud_trig.sv
// Up/down modulo counter with synchronous load, per-bit carry/borrow pulses
// and a terminal-count pulse; all outputs registered.
module counter_ud_trig
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic                clk,
    input  logic                n_rst,
    counter_ud_trig_if.slave    bus
);

    localparam logic [WIDTH-1:0]   TOP     = WIDTH'(MODULUS - 1);
    localparam logic [CNT_MAX_W:0] MOD_EXT = (CNT_MAX_W+1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] trig_q;
    logic             tc_q;
    logic [WIDTH-1:0] next;
    logic [WIDTH-1:0] trig;
    logic             wrap;
    logic [WIDTH-1:0] ld_clamped;
    dir_e             dir;

    // Direction decode, next value and clamped load value.
    always_comb begin
        dir        = bus.up ? DIR_UP : DIR_DOWN;
        next       = WIDTH'(next_count(CNT_MAX_W'(count_q), dir, MOD_EXT));
        ld_clamped = (bus.ld_val > TOP) ? TOP : bus.ld_val;
    end

    counter_trig_gen #(
        .WIDTH (WIDTH)
    ) u_trig_gen (
        .count (count_q),
        .next  (next),
        .dir   (dir),
        .trig  (trig),
        .wrap  (wrap)
    );

    // State update: load over count over hold; pulses only on a count step.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            trig_q  <= '0;
            tc_q    <= 1'b0;
        end else if (!bus.n_ld) begin
            count_q <= ld_clamped;
            trig_q  <= '0;
            tc_q    <= 1'b0;
        end else if (!bus.n_en) begin
            count_q <= next;
            trig_q  <= trig;
            tc_q    <= wrap;
        end else begin
            trig_q  <= '0;
            tc_q    <= 1'b0;
        end
    end

    assign bus.count    = count_q;
    assign bus.trig_out = trig_q;
    assign bus.tc       = tc_q;

endmodule

// File: tb/tb_counter_ud_trig.sv
// Directed bench: a full-range (mod 16) and a mod-10 counter, both 4 bits wide.
module tb_counter_ud_trig;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    counter_ud_trig_if #(.WIDTH(4)) bus_a ();
    counter_ud_trig_if #(.WIDTH(4)) bus_b ();

    counter_ud_trig #(.WIDTH(4), .MODULUS(16)) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_a.slave)
    );

    counter_ud_trig #(.WIDTH(4), .MODULUS(10)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_a(input string tag, input int cnt, input int trg, input int t);
        check({tag, ".a.count"}, 32'(bus_a.count),    32'(cnt));
        check({tag, ".a.trig"},  32'(bus_a.trig_out), 32'(trg));
        check({tag, ".a.tc"},    32'(bus_a.tc),       32'(t));
    endtask

    task automatic check_b(input string tag, input int cnt, input int trg, input int t);
        check({tag, ".b.count"}, 32'(bus_b.count),    32'(cnt));
        check({tag, ".b.trig"},  32'(bus_b.trig_out), 32'(trg));
        check({tag, ".b.tc"},    32'(bus_b.tc),       32'(t));
    endtask

    // Inputs change 1 ns after a rising edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev;
        int exp_v;

        bus_a.n_en = 1'b1; bus_a.up = 1'b1; bus_a.n_ld = 1'b1; bus_a.ld_val = '0;
        bus_b.n_en = 1'b1; bus_b.up = 1'b1; bus_b.n_ld = 1'b1; bus_b.ld_val = '0;

        repeat (5) tick();
        check_a("reset", 0, 0, 0);
        check_b("reset", 0, 0, 0);
        n_rst = 1'b1;

        // Full-range up count: 0..15 then wrap to 0.
        bus_a.n_en = 1'b0;
        bus_a.up   = 1'b1;
        prev = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_v = i % 16;
            check_a($sformatf("up%0d", i), exp_v, prev & ~exp_v & 15, (exp_v == 0) ? 1 : 0);
            prev = exp_v;
        end

        // Down from 0 wraps to 15, then 15 -> 14.
        bus_a.up = 1'b0;
        tick(); check_a("dn_wrap", 15, 4'hF, 1);
        tick(); check_a("dn_15_14", 14, 0, 0);

        // Load 8 then step down to 7.
        bus_a.n_ld = 1'b0; bus_a.ld_val = 4'd8;
        tick(); check_a("ld8", 8, 0, 0);
        bus_a.n_ld = 1'b1;
        tick(); check_a("dn_8_7", 7, 4'b0111, 0);

        // Hold for two cycles.
        bus_a.n_en = 1'b1;
        tick(); check_a("hold1", 7, 0, 0);
        tick(); check_a("hold2", 7, 0, 0);

        // Load beats count enable.
        bus_a.n_en = 1'b0; bus_a.up = 1'b1;
        bus_a.n_ld = 1'b0; bus_a.ld_val = 4'd5;
        tick(); check_a("ld5", 5, 0, 0);
        bus_a.n_ld = 1'b1; bus_a.n_en = 1'b1;

        // Modulus 10: load clamps, wraps both ways, direction changes per edge.
        bus_b.n_ld = 1'b0; bus_b.ld_val = 4'd12;
        tick(); check_b("ld12", 9, 0, 0);
        bus_b.n_ld = 1'b1; bus_b.n_en = 1'b0; bus_b.up = 1'b1;
        tick(); check_b("m10_up_wrap", 0, 4'b1001, 1);
        bus_b.up = 1'b0;
        tick(); check_b("m10_dn_wrap", 9, 4'b1001, 1);
        tick(); check_b("m10_dn_9_8", 8, 0, 0);
        bus_b.up = 1'b1;
        tick(); check_b("m10_up_8_9", 9, 0, 0);
        bus_b.n_en = 1'b1;
        tick(); check_b("m10_hold", 9, 0, 0);

        // Async reset between edges while counter A reads 7 with a pulse active.
        bus_a.n_ld = 1'b0; bus_a.ld_val = 4'd8;
        tick();
        bus_a.n_ld = 1'b1; bus_a.n_en = 1'b0; bus_a.up = 1'b0;
        tick(); check_a("pre_rst", 7, 4'b0111, 0);
        #2 n_rst = 1'b0;
        #1 check_a("async_rst", 0, 0, 0);
        check_b("async_rst", 0, 0, 0);
        bus_a.up = 1'b1;
        tick(); check_a("in_rst", 0, 0, 0);
        n_rst = 1'b1;
        #1 check_a("rel", 0, 0, 0);
        tick(); check_a("restart1", 1, 0, 0);
        tick(); check_a("restart2", 2, 4'b0001, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
